// File: rtl/pll_lock_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock and holds the core in reset until lock is stable.
// Optional retry limit with a terminal FAIL state is enabled by defining PLL_RETRY_LIMIT_EN.
`timescale 1ns/1ps
module pll_lock_reset_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 4
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_lost_cnt,
    output logic       fail
);

    localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int MAX_CYC = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [TW-1:0] TMR_MAX     = {TW{1'b1}};
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3
`ifdef PLL_RETRY_LIMIT_EN
        , FAIL    = 3'd4
`endif
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : (val + 8'd1);
    endfunction

    state_t         state_r;
    state_t         state_nx_s;
    logic [1:0]     sync_r;
    logic           locked_s;
    logic [TW-1:0]  timer_r;
    logic [7:0]     retry_r;
    logic [7:0]     lost_r;
    logic           timer_clr_s;
    logic           retry_inc_s;
    logic           retry_clr_s;
    logic           lost_inc_s;
    logic           pll_rst_r;
    logic           sys_reset_r;
    logic           ready_r;
    logic           fail_r;

    assign locked_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_locked};
        end
    end

    // Next-state and counter-control decode; force_relock outranks lock changes and timeout
    always_comb begin
        state_nx_s  = state_r;
        retry_inc_s = 1'b0;
        lost_inc_s  = 1'b0;
        if (force_relock) begin
            state_nx_s = RESET_PLL;
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (timer_r == RST_LAST) state_nx_s = WAIT_LOCK;
                    else                     state_nx_s = RESET_PLL;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx_s = STABLE;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        retry_inc_s = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                        if (sat_inc8(retry_r) == 8'(MAX_RETRIES)) state_nx_s = FAIL;
                        else                                      state_nx_s = RESET_PLL;
`else
                        state_nx_s = RESET_PLL;
`endif
                    end else begin
                        state_nx_s = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    if (!locked_s)                   state_nx_s = WAIT_LOCK;
                    else if (timer_r == STABLE_LAST) state_nx_s = RUN;
                    else                             state_nx_s = STABLE;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nx_s = WAIT_LOCK;
                        lost_inc_s = 1'b1;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
`ifdef PLL_RETRY_LIMIT_EN
                FAIL:    state_nx_s = FAIL;
`endif
                default: state_nx_s = RESET_PLL;
            endcase
        end
        // A relock request inside RESET_PLL restarts the pulse without a state change
        timer_clr_s = force_relock | (state_nx_s != state_r);
        retry_clr_s = force_relock | ((state_nx_s == RUN) & (state_r != RUN));
    end

    // State, timer, retry and loss counters; outputs registered from the next state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RESET_PLL;
            timer_r     <= '0;
            retry_r     <= 8'd0;
            lost_r      <= 8'd0;
            pll_rst_r   <= 1'b1;
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (timer_clr_s)            timer_r <= '0;
            else if (timer_r != TMR_MAX) timer_r <= timer_r + TW'(1);
            else                        timer_r <= timer_r;
            if (retry_clr_s)      retry_r <= 8'd0;
            else if (retry_inc_s) retry_r <= sat_inc8(retry_r);
            else                  retry_r <= retry_r;
            if (lost_inc_s) lost_r <= sat_inc8(lost_r);
            else            lost_r <= lost_r;
`ifdef PLL_RETRY_LIMIT_EN
            pll_rst_r <= (state_nx_s == RESET_PLL) | (state_nx_s == FAIL);
            fail_r    <= (state_nx_s == FAIL);
`else
            pll_rst_r <= (state_nx_s == RESET_PLL);
            fail_r    <= 1'b0;
`endif
            sys_reset_r <= (state_nx_s != RUN);
            ready_r     <= (state_nx_s == RUN);
        end
    end

    assign pll_rst       = pll_rst_r;
    assign sys_reset     = sys_reset_r;
    assign ready         = ready_r;
    assign lock_lost_cnt = lost_r;
`ifdef PLL_RETRY_LIMIT_EN
    assign fail = fail_r;
`else
    assign fail = 1'b0;
`endif

endmodule
